// File: rtl/store_align_unit_pkg.sv
// Shared definitions for the store alignment unit: size codes, FSM states
// and the byte-mask helper used to place a store inside a double-word window.
package store_align_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  // Mask is 16 bits wide so it covers two 64-bit words; callers slice 2*B bits.
  function automatic logic [15:0] byte_mask(input logic [1:0] funct3, input logic [2:0] off);
    logic [15:0] base;
    case (funct3)
      SZ_B:    base = 16'h0001;
      SZ_H:    base = 16'h0003;
      SZ_W:    base = 16'h000F;
      SZ_D:    base = 16'h00FF;
      default: base = 16'h0000;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/store_align_unit_queue.sv
// Store queue: FIFO with wrap-bit pointers, exposing the head entry and the
// entry behind it so the issuing FSM can chain beats without a bubble.
module store_queue
  import store_align_unit_pkg::*;
#(
  parameter int W     = 66,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [W-1:0] second,
  output logic         empty,
  output logic         full,
  output logic         second_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] rd_next_idx;
  logic [W-1:0]  mem [DEPTH];

  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign second_valid = (count > {{AW{1'b0}}, 1'b1});
  assign rd_next_idx  = rd_ptr[AW-1:0] + AW'(1);
  assign head         = mem[rd_ptr[AW-1:0]];
  assign second       = mem[rd_next_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: queues stores, lane-shifts them into cache write beats.
// Optional macro STORE_SPLIT_EN issues word-crossing stores as two beats.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [1:0]          req_funct3,
  input  logic [DATA_W-1:0]   req_data,
  output logic                dc_valid,
  input  logic                dc_ready,
  output logic [31:0]         dc_addr,
  output logic [DATA_W/8-1:0] dc_we,
  output logic [DATA_W-1:0]   dc_wdata,
  output logic                misalign_err,
  output logic                busy
);

  localparam int B     = DATA_W / 8;
  localparam int OFF_W = $clog2(B);
  localparam int EW    = 32 + 2 + DATA_W;

`ifdef STORE_SPLIT_EN
  localparam logic SPLIT = 1'b1;
`else
  localparam logic SPLIT = 1'b0;
`endif

  state_t             state;
  state_t             state_n;
  logic               push;
  logic               pop;
  logic               load;
  logic               load_hi;
  logic               err_n;
  logic [EW-1:0]      req_entry;
  logic [EW-1:0]      q_head;
  logic [EW-1:0]      q_second;
  logic               q_empty;
  logic               q_full;
  logic               q_second_valid;
  logic               use_q;
  logic [EW-1:0]      cand;
  logic               cand_avail;
  logic               cand_ok;
  logic [31:0]        c_addr;
  logic [1:0]         c_f3;
  logic [DATA_W-1:0]  c_data;
  logic [OFF_W-1:0]   c_off;
  logic [15:0]        c_mask16;
  logic [2*B-1:0]     c_mask;
  logic [2*DATA_W-1:0] c_ext;
  logic [2*DATA_W-1:0] c_fdata;
  logic               c_illegal;
  logic [B-1:0]       hi_we;
  logic [DATA_W-1:0]  hi_wdata;

  assign req_ready = !q_full && !rst;
  assign push      = req_valid && req_ready;
  assign req_entry = {req_addr, req_funct3, req_data};
  assign dc_valid  = (state == BEAT0) || (state == BEAT1);
  assign busy      = !q_empty || dc_valid;

  store_queue #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_data    (req_entry),
    .pop          (pop),
    .head         (q_head),
    .second       (q_second),
    .empty        (q_empty),
    .full         (q_full),
    .second_valid (q_second_valid)
  );

  // Candidate for the next beat: queue head from IDLE, the entry behind the head
  // once the head pops, or the incoming request when it is about to become head.
  always_comb begin
    use_q = (state == IDLE) ? !q_empty : q_second_valid;
    if (use_q) begin
      cand = (state == IDLE) ? q_head : q_second;
    end else begin
      cand = req_entry;
    end
    cand_avail = use_q || push;
    {c_addr, c_f3, c_data} = cand;
    c_off     = c_addr[OFF_W-1:0];
    c_mask16  = byte_mask(c_f3, 3'(c_off));
    c_mask    = c_mask16[2*B-1:0];
    c_ext     = {{DATA_W{1'b0}}, c_data};
    c_fdata   = c_ext << {c_off, 3'b000};
    c_illegal = ((DATA_W == 32) && (c_f3 == SZ_D)) || (!SPLIT && (|c_mask[2*B-1:B]));
    cand_ok   = cand_avail && !c_illegal;
  end

  // Next-state logic; an illegal candidate after a pop is left for IDLE to discard.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    load_hi = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty && c_illegal) begin
          pop   = 1'b1;
          err_n = 1'b1;
        end else if (cand_ok) begin
          load    = 1'b1;
          state_n = BEAT0;
        end else begin
          state_n = IDLE;
        end
      end
      BEAT0: begin
        if (dc_ready) begin
          if (SPLIT && (|hi_we)) begin
            load_hi = 1'b1;
            state_n = BEAT1;
          end else begin
            pop     = 1'b1;
            load    = cand_ok;
            state_n = cand_ok ? BEAT0 : IDLE;
          end
        end else begin
          state_n = BEAT0;
        end
      end
      BEAT1: begin
        if (dc_ready) begin
          pop     = 1'b1;
          load    = cand_ok;
          state_n = cand_ok ? BEAT0 : IDLE;
        end else begin
          state_n = BEAT1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and beat output registers; outputs only change on a load or a finished beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dc_addr      <= 32'h0000_0000;
      dc_we        <= '0;
      dc_wdata     <= '0;
      hi_we        <= '0;
      hi_wdata     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      misalign_err <= err_n;
      if (load) begin
        dc_addr  <= c_addr & ~32'(B - 1);
        dc_we    <= c_mask[B-1:0];
        dc_wdata <= c_fdata[DATA_W-1:0];
        hi_we    <= c_mask[2*B-1:B];
        hi_wdata <= c_fdata[2*DATA_W-1:DATA_W];
      end else if (load_hi) begin
        dc_addr  <= dc_addr + 32'(B);
        dc_we    <= hi_we;
        dc_wdata <= hi_wdata;
        hi_we    <= '0;
      end else if (state_n == IDLE) begin
        dc_addr  <= 32'h0000_0000;
        dc_we    <= '0;
        dc_wdata <= '0;
        hi_we    <= '0;
      end else begin
        dc_addr  <= dc_addr;
      end
    end
  end

endmodule

// File: doc/store_align_unit.md
STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 Parameter DATA_W, default 32, sets the data-cache word width in bits; only 32 and 64 are legal.
REQ-002 Parameter DEPTH, default 2, sets the number of store-queue entries; must be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  store request valid.
REQ-006 req_ready  output  1  queue can accept a request.
REQ-007 req_addr  input  32  store byte address.
REQ-008 req_funct3  input  2  size: 00 byte, 01 half, 10 word, 11 double.
REQ-009 req_data  input  DATA_W  store data, right-aligned.
REQ-010 dc_valid  output  1  cache write beat valid.
REQ-011 dc_ready  input  1  cache accepts the beat.
REQ-012 dc_addr  output  32  word-aligned beat address, low log2(DATA_W/8) bits zero.
REQ-013 dc_we  output  DATA_W/8  byte write enables.
REQ-014 dc_wdata  output  DATA_W  lane-shifted write data.
REQ-015 misalign_err  output  1  one-cycle pulse when a store is discarded.
REQ-016 busy  output  1  queue non-empty or a beat pending.

Function
REQ-017 A request transfers when req_valid and req_ready are both high; req_ready shall equal "queue not full", independent of a same-cycle pop.
REQ-018 The queue shall be FIFO; push and pop in the same cycle shall be legal when the queue is neither full nor empty.
REQ-019 Pointers shall wrap modulo DEPTH; full and empty shall be distinguished by an extra wrap bit.
REQ-020 With B = DATA_W/8, off = addr mod B and size = 1 << funct3, the full mask shall be ((1 << size) - 1) << off over 2B bits, and the full data shall be req_data << (8*off) over 2*DATA_W bits.
REQ-021 The FSM shall have three states: IDLE, BEAT0, BEAT1.
REQ-022 IDLE -> BEAT0 when the queue is non-empty; the head entry is latched into output registers.
REQ-023 BEAT0 drives the lower B mask bits and lower DATA_W data bits at addr with the low bits cleared.
REQ-024 BEAT0 with dc_ready: go to BEAT1 if the upper mask bits are non-zero and the split is enabled; otherwise pop, then go to BEAT0 if the queue is still non-empty, else to IDLE.
REQ-025 BEAT1 drives the upper mask and data halves at the BEAT0 address plus B; on dc_ready it pops, with the same next-state rule as BEAT0.
REQ-026 dc_valid shall be high only in BEAT0 and BEAT1.
REQ-027 dc_addr, dc_we and dc_wdata shall hold stable while dc_valid is high and dc_ready is low.
REQ-028 Minimum latency is one cycle: a request accepted in cycle N into an empty queue with IDLE gives dc_valid in cycle N+1.
REQ-029 funct3 = 11 with DATA_W = 32 is illegal; at the head it gives misalign_err for one cycle, the entry is popped, and no beat is issued.
REQ-030 dc_we shall never be all-zero while dc_valid is high.

Reset
REQ-031 rst empties the queue, sets the FSM to IDLE, and drives req_ready = 0, dc_valid = 0, dc_we = 0, dc_wdata = 0, dc_addr = 0, misalign_err = 0 and busy = 0 in the cycle after assertion.
REQ-032 A reset during a beat (including BEAT1) abandons the beat; no further beat for that entry is issued, even if dc_ready was high in the reset cycle.
REQ-033 req_ready shall rise in the first cycle after rst deasserts.

Configuration
REQ-034 Macro STORE_SPLIT_EN: when defined, a store crossing a word boundary (off + size > B) is issued as two beats, BEAT0 then BEAT1, and misalign_err is never asserted for legal sizes.
REQ-035 When STORE_SPLIT_EN is undefined, a crossing store at the head pulses misalign_err for one cycle, is popped, and issues no beat; BEAT1 is unreachable.

Structure
REQ-036 The shared package holds the size encoding constants (SZ_B, SZ_H, SZ_W, SZ_D), the FSM state typedef, and a function computing the byte mask from size and offset.
REQ-037 The queue is one sub-module, store_queue, parametrised by entry width and DEPTH.

Verification
REQ-038 DATA_W = 32: sb addr 0x1003, data 0xAB -> one beat, dc_addr 0x1000, dc_we 1000, dc_wdata 0xAB000000.
REQ-039 DATA_W = 32, STORE_SPLIT_EN defined: sw addr 0x2002, data 0x11223344 -> beat 0x2000, we 1100, wdata 0x33440000; then beat 0x2004, we 0011, wdata 0x00001122.
REQ-040 Same stimulus as REQ-039 with STORE_SPLIT_EN undefined -> misalign_err pulses once, no dc_valid, busy falls.
REQ-041 Hold dc_ready = 0 and push three stores with DEPTH = 2 -> req_ready low after two pushes; dc outputs stable; release dc_ready -> all stores drain in order.
REQ-042 Assert rst in BEAT1 of the REQ-039 store -> the second beat never appears; queue empty; req_ready = 1 the cycle after release.
REQ-043 DATA_W = 64: sd addr 0x3000, data 0x0102030405060708 -> one beat, dc_we 0xFF; sd with funct3 = 11 at DATA_W = 32 -> misalign_err.
